// File: rtl/sysarray_result_drain_pkg.sv
// Shared constants and state encoding for the systolic-array result drain.
package sysarray_result_drain_pkg;

  localparam int unsigned WIDTH           = 8;
  localparam int unsigned RES_W           = 2 * WIDTH;
  localparam int unsigned WORDS_PER_FRAME = 5;
  localparam int unsigned LAST_IDX        = WORDS_PER_FRAME - 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/sysarray_frame_fifo.sv
// Frame buffer: FRAMES slots of one full result frame each, with head/next peek.
module sysarray_frame_fifo
  import sysarray_result_drain_pkg::*;
#(
  parameter int unsigned DW     = WORDS_PER_FRAME * RES_W,
  parameter int unsigned FRAMES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [DW-1:0]                 push_data_i,
  input  logic                          pop_i,
  output logic [DW-1:0]                 head_o,
  output logic [DW-1:0]                 next_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FRAMES+1)-1:0]   count_o
);

  localparam int unsigned PW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned CW = $clog2(FRAMES + 1);

  logic [DW-1:0] mem_q [FRAMES];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Frame storage; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because FRAMES is a power of two.
  always_comb begin
    wptr_d  = push_i ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_i  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign next_o  = mem_q[rptr_q + PW'(1)];
  assign full_o  = (count_q == CW'(FRAMES));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sysarray_result_drain.sv
// Captures array result frames on done rising edges and serializes them as
// five valid/ready words per frame (result0..3, then importance).
module sysarray_result_drain
  import sysarray_result_drain_pkg::*;
#(
  parameter int unsigned WIDTH  = sysarray_result_drain_pkg::WIDTH,
  parameter int unsigned FRAMES = 2
) (
  input  logic               clk,
  input  logic               _reset,
  input  logic               done,
  input  logic [2*WIDTH-1:0] result0,
  input  logic [2*WIDTH-1:0] result1,
  input  logic [2*WIDTH-1:0] result2,
  input  logic [2*WIDTH-1:0] result3,
  input  logic [2*WIDTH-1:0] importance,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_idx,
  output logic               out_last,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned FW = WORDS_PER_FRAME * RW;
  localparam int unsigned CW = $clog2(FRAMES + 1);

  state_e        state_q, state_d;
  logic          done_q, armed_q;
  logic [2:0]    idx_q, idx_d;
  logic [RW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic          done_rise, hs, pop, push, keep;
  logic [FW-1:0] push_frame, nxt_frame, fifo_head, fifo_next;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign push_frame = {importance, result3, result2, result1, result0};

  sysarray_frame_fifo #(
    .DW     (FW),
    .FRAMES (FRAMES)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (_reset),
    .push_i      (push),
    .push_data_i (push_frame),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .next_o      (fifo_next),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Edge detect, buffer admission and the word to present after this edge.
  // The head frame stays in the buffer until its last word is accepted, so
  // the next presented frame is either the current head, the one behind it,
  // or the frame being captured right now when the buffer would otherwise
  // be empty.
  always_comb begin
    done_rise = done & ~done_q & armed_q;
    hs        = (state_q == SEND) & out_ready;
    pop       = hs & last_q;
    push      = done_rise & (~fifo_full | pop);
    ovf_d     = ovf_q | (done_rise & ~push);
    nxt_frame = fifo_head;
    keep      = 1'b0;

    if (pop) begin
      if (fifo_count > CW'(1)) begin
        nxt_frame = fifo_next;
      end else begin
        nxt_frame = push_frame;
      end
      keep = (fifo_count > CW'(1)) | push;
    end else begin
      if (fifo_empty) begin
        nxt_frame = push_frame;
      end
      keep = ~fifo_empty | push;
    end

    if ((state_q != SEND) || pop) begin
      idx_d = '0;
    end else if (hs) begin
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end

    state_d = keep ? SEND : IDLE;
    valid_d = keep;
    busy_d  = keep;
    last_d  = keep & (idx_d == 3'(LAST_IDX));

    data_d = '0;
    if (keep) begin
      case (idx_d)
        3'd0:    data_d = nxt_frame[0*RW +: RW];
        3'd1:    data_d = nxt_frame[1*RW +: RW];
        3'd2:    data_d = nxt_frame[2*RW +: RW];
        3'd3:    data_d = nxt_frame[3*RW +: RW];
        default: data_d = nxt_frame[4*RW +: RW];
      endcase
    end
  end

  // FSM, serializer output registers and done history.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      armed_q <= armed_q | ~done;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sysarray_result_drain.sv
// Directed bench for sysarray_result_drain with a word-level scoreboard.
module tb_sysarray_result_drain;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned RW     = 2 * WIDTH;
  localparam int unsigned FRAMES = 2;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [2:0]    idx;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          done;
  logic [RW-1:0] result0, result1, result2, result3, importance;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          overflow;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  sysarray_result_drain #(
    .WIDTH  (WIDTH),
    .FRAMES (FRAMES)
  ) dut (
    .clk        (clk),
    ._reset     (rst_n),
    .done       (done),
    .result0    (result0),
    .result1    (result1),
    .result2    (result2),
    .result3    (result3),
    .importance (importance),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                            input logic [RW-1:0] r2, input logic [RW-1:0] r3,
                            input logic [RW-1:0] imp);
    sb.push_back('{data: r0,  idx: 3'd0});
    sb.push_back('{data: r1,  idx: 3'd1});
    sb.push_back('{data: r2,  idx: 3'd2});
    sb.push_back('{data: r3,  idx: 3'd3});
    sb.push_back('{data: imp, idx: 3'd4});
  endtask

  task automatic set_results(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                             input logic [RW-1:0] r2, input logic [RW-1:0] r3,
                             input logic [RW-1:0] imp);
    result0 = r0; result1 = r1; result2 = r2; result3 = r3; importance = imp;
  endtask

  // One-cycle done pulse; the frame is expected on the output only if kept.
  task automatic pulse(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                       input logic [RW-1:0] r2, input logic [RW-1:0] r3,
                       input logic [RW-1:0] imp, input bit kept);
    set_results(r0, r1, r2, r3, imp);
    done = 1'b1;
    if (kept) push_frame(r0, r1, r2, r3, imp);
    step();
    done = 1'b0;
  endtask

  // Consume nwords against the scoreboard; toggle=1 alternates ready 1,0,...
  task automatic drain(input int nwords, input bit toggle, input int budget);
    int   got;
    exp_t e;
    got = 0;
    for (int c = 0; c < budget && got < nwords; c++) begin
      out_ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (!toggle && got > 0) chk("no_bubble", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("extra_word", 32'(out_valid), 32'd0);
        end else begin
          e = sb[0];
          chk("data", 32'(out_data), 32'(e.data));
          chk("idx", 32'(out_idx), 32'(e.idx));
          chk("last", 32'(out_last), 32'(e.idx == 3'd4));
          if (out_ready) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      step();
    end
    chk("drain_count", 32'(got), 32'(nwords));
    out_ready = 1'b0;
  endtask

  task automatic expect_idle(input int cycles);
    out_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    done      = 1'b0;
    out_ready = 1'b0;
    set_results('0, '0, '0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Basic frame, ready held high, first word one cycle after capture
    chk("pre_valid", 32'(out_valid), 32'd0);
    pulse(16'd2, 16'd2, 16'd0, 16'd0, 16'd4, 1'b1);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_busy", 32'(busy), 32'd1);
    drain(5, 1'b0, 20);
    expect_idle(3);

    // Same frame with ready toggling; words held while stalled
    pulse(16'd2, 16'd2, 16'd0, 16'd0, 16'd4, 1'b1);
    drain(5, 1'b1, 30);
    expect_idle(3);

    // Signed extremes, three edges with no consumer: third frame dropped
    out_ready = 1'b0;
    pulse(16'd1, 16'd2, 16'd3, 16'd4, 16'h8000, 1'b1);
    step();
    pulse(16'hFFFF, 16'h7FFF, 16'd5, 16'hFFFD, 16'd7, 1'b1);
    step();
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    pulse(16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 1'b0);
    step();
    chk("ovf_after_drop", 32'(overflow), 32'd1);
    chk("busy_full", 32'(busy), 32'd1);
    drain(10, 1'b0, 40);
    expect_idle(3);
    chk("sb_empty_drop", 32'(sb.size()), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame, then a done held high across release
    pulse(16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk("midframe_idx", 32'(out_idx), 32'd2);
    chk("midframe_data", 32'(out_data), 32'd33);
    done  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_idx", 32'(out_idx), 32'd0);
    chk("async_data", 32'(out_data), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("held_done_valid", 32'(out_valid), 32'd0);
      chk("held_done_busy", 32'(busy), 32'd0);
    end
    done = 1'b0;
    step();
    pulse(16'd100, 16'd200, 16'hFF00, 16'd300, 16'h1234, 1'b1);
    chk("rearm_valid", 32'(out_valid), 32'd1);
    drain(5, 1'b0, 20);
    expect_idle(2);

    // Full buffer with a done edge on the same cycle as the last handshake
    out_ready = 1'b0;
    pulse(16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 1'b1);
    step();
    pulse(16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 1'b1);
    step();
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      e = sb[0];
      chk("f1_valid", 32'(out_valid), 32'd1);
      chk("f1_data", 32'(out_data), 32'(e.data));
      chk("f1_idx", 32'(out_idx), 32'(e.idx));
      if (c == 4) begin
        chk("f1_last", 32'(out_last), 32'd1);
        set_results(16'd41, 16'd42, 16'd43, 16'd44, 16'hBEEF);
        done = 1'b1;
      end
      void'(sb.pop_front());
      step();
    end
    done = 1'b0;
    push_frame(16'd41, 16'd42, 16'd43, 16'd44, 16'hBEEF);
    chk("no_bubble_f1f2", 32'(out_valid), 32'd1);
    chk("same_cycle_ovf", 32'(overflow), 32'd0);
    drain(10, 1'b0, 40);
    expect_idle(3);
    chk("sb_empty_same_cycle", 32'(sb.size()), 32'd0);

    // done held high for 10 cycles captures exactly one frame
    out_ready = 1'b0;
    set_results(16'd7, 16'd6, 16'd5, 16'd4, 16'd3);
    push_frame(16'd7, 16'd6, 16'd5, 16'd4, 16'd3);
    done = 1'b1;
    repeat (10) step();
    done = 1'b0;
    step();
    chk("held_busy", 32'(busy), 32'd1);
    drain(5, 1'b0, 20);
    expect_idle(4);
    chk("held_ovf", 32'(overflow), 32'd0);
    chk("sb_empty_final", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sysarray_result_drain.md
SYSARRAY_RESULT_DRAIN -- requirements
Module: sysarray_result_drain

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width; result words are 2*WIDTH bits signed.
REQ-002 Parameter FRAMES, default 2, SHALL set the number of buffered result frames (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 _reset  input  1  reset, asynchronous, active-low.
REQ-005 done  input  1  array completion level; a frame is captured on its 0->1 transition.
REQ-006 result0..result3  input  2*WIDTH each  signed array results.
REQ-007 importance  input  2*WIDTH  signed array importance score.
REQ-008 out_data  output  2*WIDTH  current serialized word.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-011 out_idx  output  3  word index within the frame: 0..3 for result0..3, 4 for importance.
REQ-012 out_last  output  1  high with out_valid when out_idx equals 4.
REQ-013 busy  output  1  high while any frame is buffered or being sent.
REQ-014 overflow  output  1  sticky flag; a frame was dropped.

Function
REQ-015 The block SHALL register done and detect a rising edge as done high with the previous value low; a constant-high done SHALL capture exactly one frame.
REQ-016 On a detected edge the block SHALL write {result0..3, importance} as one frame into the buffer if space is available.
REQ-017 Space SHALL count as available when buffered frames are fewer than FRAMES, or when the buffer is full and the last word of the head frame is accepted in the same cycle.
REQ-018 When an edge arrives with no space, the frame SHALL be dropped, overflow SHALL be set, and buffered frames SHALL be unaffected.
REQ-019 FSM states SHALL be IDLE and SEND; IDLE->SEND when the buffer is non-empty; SEND->IDLE after the out_last handshake if the buffer is then empty; otherwise the FSM stays in SEND with out_idx reset to 0.
REQ-020 out_valid SHALL rise the cycle after the capture edge, so capture-to-first-word latency is 1 cycle, or 2 cycles when done is measured from the array.
REQ-021 Words SHALL be emitted in the order idx 0,1,2,3,4; out_idx SHALL advance only on a handshake.
REQ-022 out_data and out_idx SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 Back-to-back frames SHALL stream without a bubble: idx 0 of the next frame is valid the cycle after the out_last handshake.
REQ-024 Values SHALL pass through unmodified; the block performs no arithmetic beyond the pointer and index counters.
REQ-025 Read and write frame pointers SHALL wrap modulo FRAMES; the count SHALL be correct under simultaneous capture and pop.
REQ-026 busy SHALL equal (count != 0) or (state == SEND).

Reset
REQ-027 Asserting _reset low at any time, including mid-frame, SHALL immediately clear the FSM to IDLE and clear the pointers, count, overflow, and the registered done.
REQ-028 While in reset, out_data, out_idx, out_valid, out_last, and busy SHALL all read 0; buffered frame contents need not be cleared.
REQ-029 After release, a done already high SHALL NOT be treated as an edge until it has been seen low.

Structure
REQ-030 A shared package SHALL hold WIDTH, RES_W = 2*WIDTH, WORDS_PER_FRAME = 5, and the IDLE/SEND state encoding.
REQ-031 Frame storage and pointers SHALL live in one sub-module, sysarray_frame_fifo, with push, pop, full, empty, and count; the FSM, serializer, and edge detector stay at top level.

Verification
REQ-032 Results 2,2,0,0 with importance 4, done pulse, out_ready=1 -> words 2,2,0,0,4 on idx 0..4 in five consecutive cycles, out_last on the fifth, busy low afterwards.
REQ-033 Same frame with out_ready toggling 1,0,1,0 -> each word held stable while stalled, order unchanged, exactly 5 handshakes.
REQ-034 Three done edges with out_ready=0 and FRAMES=2 -> the first two frames are kept, overflow=1, and after out_ready=1 exactly 10 words are emitted with the third frame absent.
REQ-035 Buffer full, with a done edge in the same cycle as the out_last handshake -> frame accepted, overflow stays 0, no bubble between frames.
REQ-036 _reset asserted while out_idx=2 -> out_valid=0 and busy=0 immediately; held-high done after release produces no output until it toggles low then high.
REQ-037 done held high for 10 cycles -> exactly one frame emitted.
